// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg
//   Shared definitions for the instruction-memory arbiter.
//   - IMEM_WIDTH : address/data width of the single-port imem
//   - arb_state_t: arbiter FSM states (IDLE -> ISSUE -> [WAIT] -> IDLE)
//   - OWNER_M0/OWNER_M1: encoding of the requester that owns the access
package imem_arbiter_pkg;

    localparam int IMEM_WIDTH = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

endpackage

// File: rtl/imem_rr_pick.sv
// imem_rr_pick
//   Combinational winner selection between the fetch port (req0) and the
//   debug/loader port (req1).
//   Ports:
//     req0, req1  in   pending requests
//     last_owner  in   requester granted most recently (OWNER_M0/OWNER_M1)
//     fixed_prio  in   1 = req1 always wins contention
//     grant0/1    out  one-hot winner, or both 0 when nothing is requested
module imem_rr_pick
    import imem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    input  logic fixed_prio,
    output logic grant0,
    output logic grant1
);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0 && req1) begin
            // On contention the requester that did not go last wins.
            if (fixed_prio || (last_owner == OWNER_M0)) begin
                grant1 = 1'b1;
            end else begin
                grant0 = 1'b1;
            end
        end else begin
            grant0 = req0;
            grant1 = req1;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Shares the single-port instruction memory between the instruction fetch
//   (m0, read-only) and the debug/loader port (m1, read/write). One access
//   is in flight at a time.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     m0_req/m0_addr             fetch request (held until m0_gnt)
//     m0_gnt/m0_rvalid/m0_rdata  fetch grant pulse, read-data pulse, data
//     m1_req/m1_we/m1_addr/m1_wdata  debug request (held until m1_gnt)
//     m1_gnt/m1_rvalid/m1_rdata  debug grant pulse, read-data pulse, data
//     mem_addr/mem_we/mem_wdata  registered imem controls
//     mem_rdata                  imem read data (RD_LAT cycles after mem_addr)
//     busy                       high whenever an access is in progress
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int AW         = IMEM_WIDTH,
    parameter int DW         = IMEM_WIDTH,
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic [CW-1:0] lat_cnt;
    logic [CW-1:0] lat_cnt_d;
    // last_owner doubles as the owner of the access currently in flight.
    logic          last_owner;
    logic          grant0;
    logic          grant1;
    logic          load;
    logic          capture;

    imem_rr_pick u_pick (
        .req0       (m0_req),
        .req1       (m1_req),
        .last_owner (last_owner),
        .fixed_prio (FIXED_PRIO != 0),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            lat_cnt <= '0;
        end else begin
            state_q <= state_d;
            lat_cnt <= lat_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt;
        load      = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (grant0 || grant1) begin
                    load    = 1'b1;
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                // mem_we is only ever high during ISSUE, so it marks a write.
                if (mem_we) begin
                    state_d = ARB_IDLE;
                end else begin
                    lat_cnt_d = CW'(RD_LAT - 1);
                    state_d   = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (lat_cnt == '0) begin
                    capture = 1'b1;
                    state_d = ARB_IDLE;
                end else begin
                    lat_cnt_d = lat_cnt - CW'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= OWNER_M1;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            m0_rvalid  <= 1'b0;
            m1_rvalid  <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            mem_we    <= load && grant1 && m1_we;
            m0_rvalid <= capture && (last_owner == OWNER_M0);
            m1_rvalid <= capture && (last_owner == OWNER_M1);
            if (load) begin
                last_owner <= grant1 ? OWNER_M1 : OWNER_M0;
                mem_addr   <= grant1 ? m1_addr : m0_addr;
                if (grant1) begin
                    mem_wdata <= m1_wdata;
                end
            end
            if (capture && (last_owner == OWNER_M0)) begin
                m0_rdata <= mem_rdata;
            end
            if (capture && (last_owner == OWNER_M1)) begin
                m1_rdata <= mem_rdata;
            end
        end
    end

    assign m0_gnt = (state_q == ARB_ISSUE) && (last_owner == OWNER_M0);
    assign m1_gnt = (state_q == ARB_ISSUE) && (last_owner == OWNER_M1);
    assign busy   = (state_q != ARB_IDLE);

endmodule
